mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency word memory between the CPU instruction-fetch side (read-only) and the data side (read/write).
- Sequences each access: holds memory read/write strobes, address and write data for LATENCY cycles, captures read data, and returns a one-cycle done pulse to the granted requester.
- Sits between the CPU core and the memory model; it replaces separate I/D strobes with a single arbitrated stream.

Parameters:
WORD_SIZE, 16, address and data width in bits
LATENCY, 3, memory access cycles per transfer (≥1); matches the memory's 3-cycle access counter

Ports:
clk  input  1  system clock, all state on posedge
reset  input  1  asynchronous, active-high reset
i_req  input  1  instruction fetch request, held until i_done
i_addr  input  WORD_SIZE  fetch address
i_rdata  output  WORD_SIZE  fetched word, valid with i_done, held until next I completion
i_done  output  1  one-cycle completion pulse for I side
d_req  input  1  data request, held until d_done
d_we  input  1  1 = write, 0 = read; sampled at grant
d_addr  input  WORD_SIZE  data address
d_wdata  input  WORD_SIZE  write data; sampled at grant
d_rdata  output  WORD_SIZE  read word, valid with d_done; unchanged by writes
d_done  output  1  one-cycle completion pulse for D side
m_readM  output  1  memory read strobe
m_writeM  output  1  memory write strobe
m_address  output  WORD_SIZE  memory address
m_wdata  output  WORD_SIZE  memory write data
m_rdata  input  WORD_SIZE  memory read data, valid in the last ACCESS cycle
busy  output  1  high in ACCESS and DONE
grant_d  output  1  1 = current or last grant is D side

Behaviour:
- Reset (async, any time, including mid-access):
  - FSM goes to IDLE; counter = 0.
  - All outputs 0, including m_readM, m_writeM, m_address, m_wdata, i_rdata, d_rdata, *_done, busy, grant_d.
  - Any in-flight access is aborted, and no done pulse is issued for it.
- FSM states IDLE, ACCESS, DONE:
  - IDLE: if neither req is high, stay in IDLE. Otherwise pick a winner, latch the winner's addr, d_we and d_wdata (D only), set grant_d, load counter = LATENCY-1, go to ACCESS.
  - ACCESS:
    - m_address and m_wdata are driven from latched values.
    - m_readM = 1 for I grants and D reads; m_writeM = 1 for D writes. Exactly one strobe is high.
    - Counter decrements each cycle. When it is 0, capture m_rdata into i_rdata or d_rdata (reads only), deassert strobes, and go to DONE.
  - DONE: pulse the granted side's done for exactly this cycle. Requests are ignored this cycle. Go to IDLE.
- Timing:
  - With req high in IDLE cycle 0, strobes are high in cycles 1..LATENCY and done is high in cycle LATENCY+1.
  - A back-to-back grant can occur in cycle LATENCY+2.
  - Throughput is one access per LATENCY+2 cycles.
- Handshake:
  - A requester drops req at the edge that ends its done cycle, otherwise it is re-granted.
  - Dropping req during ACCESS does not cancel the transfer; done still pulses.
  - Address or data changes after grant are ignored.
- Arbitration default (fixed priority):
  - D wins when both reqs are high in IDLE.
  - The I side can starve under continuous D traffic; this is accepted behaviour.
- The strobes m_readM and m_writeM are never both high. Outside ACCESS, both are low and m_address and m_wdata hold their last values.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined:
  - A last-grant flag (reset value = D) decides ties: on simultaneous requests, the side not granted last wins.
  - The first tie after reset therefore goes to I.
  - A lone requester is always granted.
- Undefined: fixed D-over-I priority as above; the flag logic is absent.

Test Plan:
- Reset, then I read with i_addr=0x0000 and memory word 0x9023 → m_readM high cycles 1–3, i_done pulse cycle 4, i_rdata=0x9023, d_done never asserts.
- D write d_addr=0x0050, d_wdata=0xBEEF, then D read of 0x0050 → m_writeM high for 3 cycles with m_wdata=0xBEEF; second access returns d_rdata=0xBEEF; d_rdata unchanged (0) after the write.
- i_req and d_req raised in the same cycle, 4 back-to-back rounds:
  - Without the macro: grants D,D,D,D and I is starved.
  - With ARB_ROUND_ROBIN_EN: grants I,D,I,D.
- d_req dropped in the 2nd ACCESS cycle of a read → strobe still held 3 cycles; d_done still pulses once.
- reset asserted in the 2nd ACCESS cycle of a D write → m_writeM falls to 0 asynchronously with no done pulse; after reset release, a new I request completes normally in 4 cycles.
- Parameter LATENCY=1, continuous i_req → m_readM high 1 cycle per access; i_done every 3 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates one fixed-latency memory port between I-fetch and D access; `ARB_ROUND_ROBIN_EN selects round-robin tie-break
module mem_port_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int LATENCY   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_done,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_done,
  output logic                 m_readM,
  output logic                 m_writeM,
  output logic [WORD_SIZE-1:0] m_address,
  output logic [WORD_SIZE-1:0] m_wdata,
  input  logic [WORD_SIZE-1:0] m_rdata,
  output logic                 busy,
  output logic                 grant_d
);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_we;
  logic           w_win_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic           r_last_d;
  assign w_win_d = d_req && (!i_req || !r_last_d);
`else
  assign w_win_d = d_req;
`endif
  // access sequencer: grant in IDLE, hold strobes LATENCY cycles, pulse done once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      m_readM   <= 1'b0;
      m_writeM  <= 1'b0;
      m_address <= '0;
      m_wdata   <= '0;
      busy      <= 1'b0;
      grant_d   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_d  <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: if (i_req || d_req) begin
          r_state   <= ACCESS;
          grant_d   <= w_win_d;
          r_we      <= w_win_d && d_we;
          m_address <= w_win_d ? d_addr : i_addr;
          m_wdata   <= w_win_d ? d_wdata : m_wdata;
          m_readM   <= !(w_win_d && d_we);
          m_writeM  <= w_win_d && d_we;
          busy      <= 1'b1;
          r_cnt     <= CW'(LATENCY - 1);
`ifdef ARB_ROUND_ROBIN_EN
          r_last_d  <= w_win_d;
`endif
        end
        ACCESS: if (r_cnt == '0) begin
          r_state  <= DONE;
          m_readM  <= 1'b0;
          m_writeM <= 1'b0;
          i_rdata  <= (!r_we && !grant_d) ? m_rdata : i_rdata;
          d_rdata  <= (!r_we && grant_d) ? m_rdata : d_rdata;
          i_done   <= !grant_d;
          d_done   <= grant_d;
        end else begin
          r_cnt <= r_cnt - CW'(1);
        end
        DONE: begin
          r_state <= IDLE;
          i_done  <= 1'b0;
          d_done  <= 1'b0;
          busy    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
